gpreg_bus_sequencer: RTL and testbench

Initiator side of the general-purpose register bus protocol. It accepts one transfer request at a time and drives the active-low strobes that the 8-bit registers respond to: per-register ASSERT_bar, ASSERT_LHS_bar, ASSERT_RHS_bar and LOAD_bar, plus immediate and ALU-result bus drivers. It sits between the instruction decoder and the register file, and guarantees glitch-free, single-driver, setup/hold-safe bus transfers.

---
 rtl/gpreg_bus_pkg.sv | 48 ++++
 rtl/gpreg_onehot_bar.sv | 24 ++
 rtl/gpreg_bus_sequencer.sv | 158 +++++++++++++++
 tb/tb_gpreg_bus_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpreg_bus_pkg.sv
// Shared encodings for the general-purpose register bus sequencer:
// request opcodes, FSM states and the table of which indices each opcode uses.
package gpreg_bus_pkg;

    localparam int BUS_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_MOVE     = 2'b00,
        OP_ALU      = 2'b01,
        OP_LOAD_IMM = 2'b10,
        OP_NOP      = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        logic bus_src;
        logic lhs;
        logic rhs;
        logic dst;
    } idx_use_t;

    // Only the indices an opcode actually uses take part in the range check.
    function automatic idx_use_t op_idx_use(input op_e op);
        idx_use_t u;
        u = '0;
        case (op)
            OP_MOVE: begin
                u.bus_src = 1'b1;
                u.dst     = 1'b1;
            end
            OP_ALU: begin
                u.lhs = 1'b1;
                u.rhs = 1'b1;
                u.dst = 1'b1;
            end
            OP_LOAD_IMM: u.dst = 1'b1;
            default:     u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/gpreg_onehot_bar.sv
// Index-plus-enable to active-low one-hot strobe vector. The out-of-range
// flag depends only on the index so it can veto the enable without a loop.
module gpreg_onehot_bar #(
    parameter int NREGS = 4,
    parameter int IDXW  = 2
) (
    input  logic [IDXW-1:0]  i_idx,
    input  logic             i_en,
    output logic [NREGS-1:0] o_bar,
    output logic             o_oor
);

    always_comb begin
        o_bar = '1;
        for (int i = 0; i < NREGS; i++) begin
            if (i_en && (32'(i_idx) == i)) begin
                o_bar[i] = 1'b0;
            end
        end
    end

    assign o_oor = (32'(i_idx) >= NREGS);

endmodule

// File: rtl/gpreg_bus_sequencer.sv
// Bus initiator: turns one accepted request into a SETUP/XFER/HOLD strobe
// sequence on the register file. Every output comes straight from a flop.
module gpreg_bus_sequencer
    import gpreg_bus_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int IDXW  = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    // Handshake: a request transfers on the rising CLK edge where REQ_valid
    // and REQ_ready are both high; REQ_ready is high only while IDLE and the
    // REQ_* fields are sampled on that edge alone.
    input  logic                 REQ_valid,
    output logic                 REQ_ready,
    input  logic [1:0]           REQ_op,
    input  logic [IDXW-1:0]      REQ_src,
    input  logic [IDXW-1:0]      REQ_rhs,
    input  logic [IDXW-1:0]      REQ_dst,
    input  logic [BUS_WIDTH-1:0] REQ_imm,
    output logic [NREGS-1:0]     ASSERT_bar,
    output logic [NREGS-1:0]     ASSERT_LHS_bar,
    output logic [NREGS-1:0]     ASSERT_RHS_bar,
    output logic [NREGS-1:0]     LOAD_bar,
    output logic                 IMM_oe_bar,
    output logic [BUS_WIDTH-1:0] IMM_out,
    output logic                 ALU_oe_bar,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [1:0]           DBG_state
);

    state_e                r_state;
    op_e                   r_op;
    logic [IDXW-1:0]       r_src, r_rhs, r_dst;
    logic [BUS_WIDTH-1:0]  r_imm;
    logic                  r_err;
    logic                  r_ready, r_busy, r_done, r_err_pulse;
    logic [NREGS-1:0]      r_assert_bar, r_lhs_bar, r_rhs_bar, r_load_bar;
    logic                  r_imm_oe_bar, r_alu_oe_bar;
    logic [BUS_WIDTH-1:0]  r_imm_out;

    logic                  w_accept;
    state_e                w_state_n;
    op_e                   w_op_req, w_op_n;
    idx_use_t              w_use;
    logic [IDXW-1:0]       w_src_n, w_rhs_n, w_dst_n;
    logic [BUS_WIDTH-1:0]  w_imm_n;
    logic                  w_err_req, w_err_n;
    logic                  w_active, w_bus_en, w_alu_en, w_imm_en, w_load_en;
    logic [NREGS-1:0]      w_assert_bar, w_lhs_bar, w_rhs_bar, w_load_bar;
    logic                  w_assert_oor, w_lhs_oor, w_rhs_oor, w_load_oor;

    assign w_accept = REQ_valid && r_ready;
    assign w_op_req = op_e'(REQ_op);
    assign w_use    = op_idx_use(w_op_req);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_n = SETUP;
            SETUP:   w_state_n = XFER;
            XFER:    w_state_n = HOLD;
            HOLD:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Strobes are decoded from the values the flops will hold next cycle, so
    // on the accept edge the request fields feed the decoders directly.
    assign w_src_n = w_accept ? REQ_src : r_src;
    assign w_rhs_n = w_accept ? REQ_rhs : r_rhs;
    assign w_dst_n = w_accept ? REQ_dst : r_dst;
    assign w_imm_n = w_accept ? REQ_imm : r_imm;

    assign w_err_req = (w_use.bus_src && w_assert_oor) || (w_use.lhs && w_lhs_oor) ||
                       (w_use.rhs && w_rhs_oor) || (w_use.dst && w_load_oor);
    assign w_op_n    = w_accept ? (w_err_req ? OP_NOP : w_op_req) : r_op;
    assign w_err_n   = w_accept ? w_err_req : r_err;

    assign w_active  = (w_state_n != IDLE);
    assign w_bus_en  = w_active && (w_op_n == OP_MOVE);
    assign w_alu_en  = w_active && (w_op_n == OP_ALU);
    assign w_imm_en  = w_active && (w_op_n == OP_LOAD_IMM);
    assign w_load_en = (w_state_n == XFER) && (w_op_n != OP_NOP);

    gpreg_onehot_bar #(.NREGS(NREGS), .IDXW(IDXW)) u_assert (
        .i_idx(w_src_n), .i_en(w_bus_en), .o_bar(w_assert_bar), .o_oor(w_assert_oor)
    );
    gpreg_onehot_bar #(.NREGS(NREGS), .IDXW(IDXW)) u_lhs (
        .i_idx(w_src_n), .i_en(w_alu_en), .o_bar(w_lhs_bar), .o_oor(w_lhs_oor)
    );
    gpreg_onehot_bar #(.NREGS(NREGS), .IDXW(IDXW)) u_rhs (
        .i_idx(w_rhs_n), .i_en(w_alu_en), .o_bar(w_rhs_bar), .o_oor(w_rhs_oor)
    );
    gpreg_onehot_bar #(.NREGS(NREGS), .IDXW(IDXW)) u_load (
        .i_idx(w_dst_n), .i_en(w_load_en), .o_bar(w_load_bar), .o_oor(w_load_oor)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_op         <= OP_NOP;
            r_src        <= '0;
            r_rhs        <= '0;
            r_dst        <= '0;
            r_imm        <= '0;
            r_err        <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_assert_bar <= '1;
            r_lhs_bar    <= '1;
            r_rhs_bar    <= '1;
            r_load_bar   <= '1;
            r_imm_oe_bar <= 1'b1;
            r_alu_oe_bar <= 1'b1;
            r_imm_out    <= '0;
        end else begin
            r_state     <= w_state_n;
            r_ready     <= (w_state_n == IDLE);
            r_busy      <= w_active;
            r_done      <= (w_state_n == HOLD);
            r_err_pulse <= (w_state_n == HOLD) && w_err_n;
            if (w_accept) begin
                r_op  <= w_op_n;
                r_src <= REQ_src;
                r_rhs <= REQ_rhs;
                r_dst <= REQ_dst;
                r_imm <= REQ_imm;
                r_err <= w_err_req;
            end
            r_assert_bar <= w_assert_bar;
            r_lhs_bar    <= w_lhs_bar;
            r_rhs_bar    <= w_rhs_bar;
            r_load_bar   <= w_load_bar;
            r_imm_oe_bar <= !w_imm_en;
            r_alu_oe_bar <= !w_alu_en;
            r_imm_out    <= w_imm_en ? w_imm_n : '0;
        end
    end

    assign REQ_ready      = r_ready;
    assign ASSERT_bar     = r_assert_bar;
    assign ASSERT_LHS_bar = r_lhs_bar;
    assign ASSERT_RHS_bar = r_rhs_bar;
    assign LOAD_bar       = r_load_bar;
    assign IMM_oe_bar     = r_imm_oe_bar;
    assign IMM_out        = r_imm_out;
    assign ALU_oe_bar     = r_alu_oe_bar;
    assign BUSY           = r_busy;
    assign DONE           = r_done;
    assign ERR            = r_err_pulse;
    assign DBG_state      = r_state;

endmodule

// File: tb/tb_gpreg_bus_sequencer.sv
// Bench for gpreg_bus_sequencer: a 4-register instance driven from a vector
// table and a 3-register instance used for out-of-range index requests.
module tb_gpreg_bus_sequencer;

    typedef struct {
        logic [1:0] op;
        logic [1:0] src;
        logic [1:0] rhs;
        logic [1:0] dst;
        logic [7:0] imm;
        logic [3:0] e_assert;
        logic [3:0] e_lhs;
        logic [3:0] e_rhs;
        logic [3:0] e_load;
        logic       e_imm_oe;
        logic       e_alu_oe;
        logic [7:0] e_imm_out;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_valid4 = 1'b0;
    logic       REQ_valid3 = 1'b0;
    logic [1:0] REQ_op = 2'b11;
    logic [1:0] REQ_src = '0, REQ_rhs = '0, REQ_dst = '0;
    logic [7:0] REQ_imm = '0;

    logic       REQ_ready4, IMM_oe4, ALU_oe4, BUSY4, DONE4, ERR4;
    logic [3:0] ASSERT4, LHS4, RHS4, LOAD4;
    logic [7:0] IMM_out4;
    logic [1:0] DBG4;

    logic       REQ_ready3, IMM_oe3, ALU_oe3, BUSY3, DONE3, ERR3;
    logic [2:0] ASSERT3, LHS3, RHS3, LOAD3;
    logic [7:0] IMM_out3;
    logic [1:0] DBG3;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];
    logic [3:0] mon_load_and = 4'hF;
    vec_t vecs[12];

    gpreg_bus_sequencer #(.NREGS(4), .IDXW(2)) u_dut4 (
        .CLK(CLK), .RST(RST), .REQ_valid(REQ_valid4), .REQ_ready(REQ_ready4),
        .REQ_op(REQ_op), .REQ_src(REQ_src), .REQ_rhs(REQ_rhs), .REQ_dst(REQ_dst),
        .REQ_imm(REQ_imm), .ASSERT_bar(ASSERT4), .ASSERT_LHS_bar(LHS4),
        .ASSERT_RHS_bar(RHS4), .LOAD_bar(LOAD4), .IMM_oe_bar(IMM_oe4),
        .IMM_out(IMM_out4), .ALU_oe_bar(ALU_oe4), .BUSY(BUSY4), .DONE(DONE4),
        .ERR(ERR4), .DBG_state(DBG4)
    );

    gpreg_bus_sequencer #(.NREGS(3), .IDXW(2)) u_dut3 (
        .CLK(CLK), .RST(RST), .REQ_valid(REQ_valid3), .REQ_ready(REQ_ready3),
        .REQ_op(REQ_op), .REQ_src(REQ_src), .REQ_rhs(REQ_rhs), .REQ_dst(REQ_dst),
        .REQ_imm(REQ_imm), .ASSERT_bar(ASSERT3), .ASSERT_LHS_bar(LHS3),
        .ASSERT_RHS_bar(RHS3), .LOAD_bar(LOAD3), .IMM_oe_bar(IMM_oe3),
        .IMM_out(IMM_out3), .ALU_oe_bar(ALU_oe3), .BUSY(BUSY3), .DONE(DONE3),
        .ERR(ERR3), .DBG_state(DBG3)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [1:0] op, input logic [1:0] src,
                                   input logic [1:0] rhs, input logic [1:0] dst,
                                   input logic [7:0] imm);
        vec_t v;
        v.op = op; v.src = src; v.rhs = rhs; v.dst = dst; v.imm = imm;
        v.e_assert = 4'hF; v.e_lhs = 4'hF; v.e_rhs = 4'hF; v.e_load = 4'hF;
        v.e_imm_oe = 1'b1; v.e_alu_oe = 1'b1; v.e_imm_out = 8'h00;
        case (op)
            2'b00: begin v.e_assert = ~(4'b0001 << src); v.e_load = ~(4'b0001 << dst); end
            2'b01: begin
                v.e_lhs = ~(4'b0001 << src); v.e_rhs = ~(4'b0001 << rhs);
                v.e_alu_oe = 1'b0; v.e_load = ~(4'b0001 << dst);
            end
            2'b10: begin v.e_imm_oe = 1'b0; v.e_imm_out = imm; v.e_load = ~(4'b0001 << dst); end
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- scoreboard monitor (4-register DUT) ----------------
    always @(negedge CLK) begin
        if (RST) begin
            mon_load_and = 4'hF;
        end else begin
            if (BUSY4) mon_load_and = mon_load_and & LOAD4;
            if (DONE4) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 32'(DONE4), 32'd0);
                end else begin
                    chk("sb_err_load", {27'd0, ERR4, mon_load_and}, {27'd0, exp_q.pop_front()});
                end
                mon_load_and = 4'hF;
            end
            chk("invariants",
                32'(($countones(~ASSERT4) + 32'(!IMM_oe4) + 32'(!ALU_oe4)) <= 1 &&
                    $countones(~LOAD4) <= 1 && $countones(~LHS4) <= 1 &&
                    $countones(~RHS4) <= 1), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready4();
        int n = 0;
        while (!REQ_ready4 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_ready4) chk("ready4_timeout", 32'(REQ_ready4), 32'd1);
    endtask

    task automatic wait_ready3();
        int n = 0;
        while (!REQ_ready3 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_ready3) chk("ready3_timeout", 32'(REQ_ready3), 32'd1);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        wait_ready4();
        REQ_op = v.op; REQ_src = v.src; REQ_rhs = v.rhs; REQ_dst = v.dst; REQ_imm = v.imm;
        REQ_valid4 = 1'b1;
        exp_q.push_back({1'b0, v.e_load});
        @(posedge CLK);
        #1;
        REQ_valid4 = 1'b0;
        REQ_op = 2'b00; REQ_src = ~v.src; REQ_rhs = ~v.rhs; REQ_dst = ~v.dst; REQ_imm = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("v%0d_c%0d_assert", n, c), 32'(ASSERT4), 32'(v.e_assert));
            chk($sformatf("v%0d_c%0d_lhs", n, c), 32'(LHS4), 32'(v.e_lhs));
            chk($sformatf("v%0d_c%0d_rhs", n, c), 32'(RHS4), 32'(v.e_rhs));
            chk($sformatf("v%0d_c%0d_imm_oe", n, c), 32'(IMM_oe4), 32'(v.e_imm_oe));
            chk($sformatf("v%0d_c%0d_alu_oe", n, c), 32'(ALU_oe4), 32'(v.e_alu_oe));
            chk($sformatf("v%0d_c%0d_imm_out", n, c), 32'(IMM_out4), 32'(v.e_imm_out));
            chk($sformatf("v%0d_c%0d_load", n, c), 32'(LOAD4), (c == 1) ? 32'(v.e_load) : 32'hF);
            chk($sformatf("v%0d_c%0d_busy", n, c), 32'(BUSY4), 32'd1);
            chk($sformatf("v%0d_c%0d_ready", n, c), 32'(REQ_ready4), 32'd0);
            chk($sformatf("v%0d_c%0d_done", n, c), 32'(DONE4), (c == 2) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        chk($sformatf("v%0d_idle_strobes", n), {14'd0, ASSERT4, LHS4, RHS4, LOAD4, IMM_oe4, ALU_oe4},
            32'h3FFFF);
        chk($sformatf("v%0d_idle_ready", n), 32'(REQ_ready4), 32'd1);
        chk($sformatf("v%0d_idle_busy_done", n), {30'd0, BUSY4, DONE4}, 32'd0);
    endtask

    task automatic run3(input int n, input logic [1:0] op, input logic [1:0] src,
                        input logic [1:0] rhs, input logic [1:0] dst,
                        input logic [2:0] e_assert, input logic [2:0] e_load, input logic e_err);
        wait_ready3();
        REQ_op = op; REQ_src = src; REQ_rhs = rhs; REQ_dst = dst; REQ_imm = 8'h5A;
        REQ_valid3 = 1'b1;
        @(posedge CLK);
        #1;
        REQ_valid3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("r%0d_c%0d_assert", n, c), 32'(ASSERT3), 32'(e_assert));
            chk($sformatf("r%0d_c%0d_lhs_rhs_oe", n, c), {24'd0, LHS3, RHS3, IMM_oe3, ALU_oe3},
                32'hFF);
            chk($sformatf("r%0d_c%0d_load", n, c), 32'(LOAD3), (c == 1) ? 32'(e_load) : 32'h7);
            chk($sformatf("r%0d_c%0d_busy", n, c), 32'(BUSY3), 32'd1);
            chk($sformatf("r%0d_c%0d_done", n, c), 32'(DONE3), (c == 2) ? 32'd1 : 32'd0);
            chk($sformatf("r%0d_c%0d_err", n, c), 32'(ERR3), (c == 2) ? 32'(e_err) : 32'd0);
        end
        @(negedge CLK);
        chk($sformatf("r%0d_idle", n), {28'd0, REQ_ready3, BUSY3, DONE3, ERR3}, 32'h8);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int accepts;
        int cyc;
        int last;

        vecs[0] = '{2'b00, 2'd1, 2'd0, 2'd2, 8'h00, 4'b1101, 4'b1111, 4'b1111, 4'b1011, 1'b1, 1'b1, 8'h00};
        vecs[1] = '{2'b01, 2'd0, 2'd3, 2'd0, 8'h00, 4'b1111, 4'b1110, 4'b0111, 4'b1110, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{2'b10, 2'd0, 2'd0, 2'd3, 8'hA5, 4'b1111, 4'b1111, 4'b1111, 4'b0111, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{2'b11, 2'd1, 2'd2, 2'd3, 8'h77, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 8'h00};
        vecs[4] = '{2'b00, 2'd2, 2'd0, 2'd2, 8'h00, 4'b1011, 4'b1111, 4'b1111, 4'b1011, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{2'b01, 2'd1, 2'd1, 2'd1, 8'h00, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{2'b10, 2'd0, 2'd0, 2'd0, 8'h3C, 4'b1111, 4'b1111, 4'b1111, 4'b1110, 1'b0, 1'b1, 8'h3C};
        vecs[7] = '{2'b01, 2'd3, 2'd2, 2'd2, 8'h00, 4'b1111, 4'b0111, 4'b1011, 4'b1011, 1'b1, 1'b0, 8'h00};
        for (int i = 8; i < 12; i++) begin
            vecs[i] = model(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                            8'($urandom_range(1, 255)));
        end

        // reset values
        repeat (2) @(negedge CLK);
        chk("rst_ready", 32'(REQ_ready4), 32'd0);
        chk("rst_strobes", {14'd0, ASSERT4, LHS4, RHS4, LOAD4, IMM_oe4, ALU_oe4}, 32'h3FFFF);
        chk("rst_imm_out", 32'(IMM_out4), 32'd0);
        chk("rst_busy_done_err", {29'd0, BUSY4, DONE4, ERR4}, 32'd0);
        chk("rst_state", 32'(DBG4), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", 32'(REQ_ready4), 32'd1);

        // table-driven transfers
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // out-of-range indices on the 3-register instance, plus one legal move
        run3(0, 2'b00, 2'd0, 2'd0, 2'd3, 3'b111, 3'b111, 1'b1);
        run3(1, 2'b01, 2'd1, 2'd3, 2'd0, 3'b111, 3'b111, 1'b1);
        run3(2, 2'b00, 2'd0, 2'd0, 2'd2, 3'b110, 3'b011, 1'b0);

        // three back-to-back requests with REQ_valid held high
        wait_ready4();
        accepts = 0;
        cyc = 0;
        last = 0;
        REQ_op = 2'b00; REQ_src = 2'd0; REQ_dst = 2'd1;
        REQ_valid4 = 1'b1;
        while (accepts < 3 && cyc < 40) begin
            if (REQ_ready4) begin
                exp_q.push_back({1'b0, ~(4'b0001 << REQ_dst)});
                if (accepts > 0) chk("b2b_gap", 32'(cyc - last), 32'd4);
                last = cyc;
                accepts++;
                @(posedge CLK);
                #1;
                if (accepts < 3) begin
                    REQ_src = REQ_src + 2'd1;
                    REQ_dst = REQ_dst + 2'd1;
                end else begin
                    REQ_valid4 = 1'b0;
                end
            end
            @(negedge CLK);
            cyc++;
        end
        REQ_valid4 = 1'b0;
        chk("b2b_accepts", 32'(accepts), 32'd3);
        wait_ready4();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a transfer
        @(negedge CLK);
        REQ_op = 2'b00; REQ_src = 2'd1; REQ_dst = 2'd2;
        REQ_valid4 = 1'b1;
        @(posedge CLK);
        #1;
        REQ_valid4 = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("midrst_pre_load", 32'(LOAD4), 32'hB);
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_strobes", {14'd0, ASSERT4, LHS4, RHS4, LOAD4, IMM_oe4, ALU_oe4}, 32'h3FFFF);
        chk("midrst_busy_done", {30'd0, BUSY4, DONE4}, 32'd0);
        @(negedge CLK);
        chk("midrst_ready_low", 32'(REQ_ready4), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_ready_back", 32'(REQ_ready4), 32'd1);
        chk("midrst_no_done", {30'd0, DONE4, ERR4}, 32'd0);
        repeat (3) @(negedge CLK);
        chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
